// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM encoding, counter width.
package mdu_pkg;

    localparam int CNT_W = 4;

    localparam logic [3:0] MD_NOP   = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MADD  = 4'd8;
    localparam logic [3:0] MD_MADDU = 4'd9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdState_t;

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath producing next HI/LO and a commit enable.
// Multiply-accumulate ops are present only when MDU_MADD_EN is defined.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic [31:0] hiCur,
    input  logic [31:0] loCur,
    output logic [31:0] hiNext,
    output logic [31:0] loNext,
    output logic        commitEn
);

    logic [63:0]        prodS;
    logic [63:0]        prodU;
    logic               divZero;
    logic               divOvf;
    logic [31:0]        divisor;
    logic signed [31:0] qS;
    logic signed [31:0] rS;
    logic [31:0]        qU;
    logic [31:0]        rU;

    // Sign-extending to 64 bits makes the low half of an unsigned multiply the signed product.
    assign prodS = {{32{opA[31]}}, opA} * {{32{opB[31]}}, opB};
    assign prodU = {32'd0, opA} * {32'd0, opB};

    // Substitute a harmless divisor so the dividers never see /0 or the overflowing case.
    assign divZero = (opB == 32'd0);
    assign divOvf  = (opA == 32'h8000_0000) && (opB == 32'hFFFF_FFFF);
    assign divisor = (divZero || divOvf) ? 32'd1 : opB;
    assign qS      = $signed(opA) / $signed(divisor);
    assign rS      = $signed(opA) % $signed(divisor);
    assign qU      = opA / divisor;
    assign rU      = opA % divisor;

`ifdef MDU_MADD_EN
    logic [63:0] accSum;
    assign accSum = {hiCur, loCur} + ((op == MD_MADD) ? prodS : prodU);
`endif

    always_comb begin
        hiNext   = hiCur;
        loNext   = loCur;
        commitEn = 1'b0;
        case (op)
            MD_MULT: begin
                {hiNext, loNext} = prodS;
                commitEn         = 1'b1;
            end
            MD_MULTU: begin
                {hiNext, loNext} = prodU;
                commitEn         = 1'b1;
            end
            MD_DIV: begin
                commitEn = !divZero;
                if (divOvf) begin
                    loNext = 32'h8000_0000;
                    hiNext = 32'd0;
                end else begin
                    loNext = qS;
                    hiNext = rS;
                end
            end
            MD_DIVU: begin
                commitEn = !divZero;
                loNext   = qU;
                hiNext   = rU;
            end
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU: begin
                {hiNext, loNext} = accSum;
                commitEn         = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_sched.sv
// Multi-cycle MD sequencer: fixed-latency countdown, HI/LO ownership and D-stage stall request.
// Define MDU_MADD_EN to enable madd/maddu (ops 8/9).
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | no operation pending; mthi/mtlo write HI/LO directly
//   ST_BUSY | countdown running; commit to HI/LO when counter hits 1
module mdu_sched
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic        md_instr_D,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        md_stall_req
);

    mdState_t         state;
    mdState_t         stateNext;
    logic [CNT_W-1:0] count;
    logic [3:0]       opR;
    logic [31:0]      aR;
    logic [31:0]      bR;
    logic [31:0]      hiNext;
    logic [31:0]      loNext;
    logic             commitEn;
    logic             isMul;
    logic             isDiv;
    logic             idleStart;
    logic             launch;
    logic             done;

    always_comb begin
        isMul = 1'b0;
        isDiv = 1'b0;
        case (md_op)
            MD_MULT, MD_MULTU: isMul = 1'b1;
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU: isMul = 1'b1;
`endif
            MD_DIV, MD_DIVU:   isDiv = 1'b1;
            default: ;
        endcase
    end

    assign idleStart = start && (state == ST_IDLE);
    assign launch    = idleStart && (isMul || isDiv);
    assign done      = (state == ST_BUSY) && (count == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: if (launch) stateNext = ST_BUSY;
            ST_BUSY: if (done)   stateNext = ST_IDLE;
            default:             stateNext = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_BUSY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            opR   <= MD_NOP;
            aR    <= '0;
            bR    <= '0;
        end else if (launch) begin
            count <= isDiv ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            opR   <= md_op;
            aR    <= srcA;
            bR    <= srcB;
        end else if (busy) begin
            count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (done) begin
            if (commitEn) begin
                hi <= hiNext;
                lo <= loNext;
            end
        end else if (idleStart) begin
            if (md_op == MD_MTHI) hi <= srcA;
            if (md_op == MD_MTLO) lo <= srcA;
        end
    end

    mdu_calc u_calc (
        .op       (opR),
        .opA      (aR),
        .opB      (bR),
        .hiCur    (hi),
        .loCur    (lo),
        .hiNext   (hiNext),
        .loNext   (loNext),
        .commitEn (commitEn)
    );

    assign md_stall_req = md_instr_D & (start | busy);

endmodule

// File: tb/tb_mdu_sched.sv
// Self-checking bench for mdu_sched: directed vector table, random ops vs. arithmetic model, corner sequences.
module tb_mdu_sched;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        md_instr_D;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        md_stall_req;

    int checks   = 0;
    int failures = 0;
    logic [31:0] mHi = 32'd0;
    logic [31:0] mLo = 32'd0;

    mdu_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .md_op        (md_op),
        .srcA         (srcA),
        .srcB         (srcB),
        .md_instr_D   (md_instr_D),
        .busy         (busy),
        .hi           (hi),
        .lo           (lo),
        .md_stall_req (md_stall_req)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (start && busy) $error("start asserted while busy");
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          expCyc;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: HI/LO after an op, straight from the arithmetic definitions.
    task automatic modelOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int cyc);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        cyc = 0;
        case (op)
            4'd1: begin p = 64'(sa * sb); {mHi, mLo} = p; cyc = MC; end
            4'd2: begin p = 64'(ua * ub); {mHi, mLo} = p; cyc = MC; end
            4'd3: begin
                cyc = DC;
                if (b != 32'd0) begin mLo = 32'(sa / sb); mHi = 32'(sa % sb); end
            end
            4'd4: begin
                cyc = DC;
                if (b != 32'd0) begin mLo = 32'(ua / ub); mHi = 32'(ua % ub); end
            end
            4'd5: mHi = a;
            4'd6: mLo = a;
`ifdef MDU_MADD_EN
            4'd8: begin p = 64'(sa * sb); {mHi, mLo} = {mHi, mLo} + p; cyc = MC; end
            4'd9: begin p = 64'(ua * ub); {mHi, mLo} = {mHi, mLo} + p; cyc = MC; end
`endif
            default: ;
        endcase
    endtask

    task automatic runOp(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ph, input logic [31:0] pl,
                         input logic [31:0] eh, input logic [31:0] el, input int ec);
        int cyc;
        logic holdBad;
        @(negedge clk);
        start = 1'b1; md_op = op; srcA = a; srcB = b;
        @(negedge clk);
        start = 1'b0; md_op = 4'($urandom); srcA = $urandom; srcB = $urandom;
        cyc = 0;
        holdBad = 1'b0;
        while (busy && cyc < 40) begin
            if (hi !== ph || lo !== pl) holdBad = 1'b1;
            cyc++;
            @(negedge clk);
        end
        check({name, " busyCycles"}, 64'(cyc), 64'(ec));
        check({name, " hold"}, 64'(holdBad), 64'd0);
        check({name, " hi"}, 64'(hi), 64'(eh));
        check({name, " lo"}, 64'(lo), 64'(el));
    endtask

    task automatic modelAndRun(input string name, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b);
        logic [31:0] ph, pl;
        int ec;
        ph = mHi; pl = mLo;
        modelOp(op, a, b, ec);
        runOp(name, op, a, b, ph, pl, mHi, mLo, ec);
    endtask

    initial begin
        int dummy;
        logic [3:0] rop;
        logic [31:0] ra, rb, ph, pl;

        vecs[0]  = '{MD_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, MC};
        vecs[1]  = '{MD_DIVU,  32'd7,         32'd2,        32'd1,         32'd3,         DC};
        vecs[2]  = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, DC};
        vecs[3]  = '{MD_MTHI,  32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFFD, 0};
        vecs[4]  = '{MD_DIV,   32'd9,         32'd0,        32'h1234_5678, 32'hFFFF_FFFD, DC};
        vecs[5]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, DC};
        vecs[6]  = '{MD_MTLO,  32'hFFFF_FFFF, 32'd0,        32'd0,         32'hFFFF_FFFF, 0};
`ifdef MDU_MADD_EN
        vecs[7]  = '{MD_MADDU, 32'd1,         32'd1,        32'd1,         32'd0,         MC};
`else
        vecs[7]  = '{MD_MADDU, 32'd1,         32'd1,        32'd0,         32'hFFFF_FFFF, 0};
`endif
        vecs[8]  = '{4'd7,     32'd1,         32'd1,        vecs[7].expHi, vecs[7].expLo, 0};
        vecs[9]  = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, DC};
        vecs[10] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,        MC};
        vecs[11] = '{MD_DIVU,  32'd0,         32'd0,        32'hFFFF_FFFE, 32'd1,         DC};

        reset = 1'b1; start = 1'b0; md_op = 4'd0; srcA = '0; srcB = '0; md_instr_D = 1'b1;
        repeat (2) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset stall", 64'(md_stall_req), 64'd0);
        reset = 1'b0; md_instr_D = 1'b0;

        for (int i = 0; i < 12; i++) begin
            ph = mHi; pl = mLo;
            modelOp(vecs[i].op, vecs[i].a, vecs[i].b, dummy);
            runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, ph, pl,
                  vecs[i].expHi, vecs[i].expLo, vecs[i].expCyc);
        end

        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000_000F;
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            if ($urandom_range(0, 9) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            modelAndRun($sformatf("rnd%0d op%0d", i, rop), rop, ra, rb);
        end

        // Stall held from the start cycle through the whole busy window.
        @(negedge clk);
        start = 1'b1; md_op = MD_MULT; srcA = 32'd3; srcB = 32'd4; md_instr_D = 1'b1;
        #1 check("stall start", 64'(md_stall_req), 64'd1);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < MC; i++) begin
            check($sformatf("stall busy%0d", i), {62'd0, busy, md_stall_req}, 64'd3);
            @(negedge clk);
        end
        check("stall after busy", {62'd0, busy, md_stall_req}, 64'd0);
        modelOp(MD_MULT, 32'd3, 32'd4, dummy);
        check("stall mult lo", 64'(lo), 64'd12);
        check("stall mult hi", 64'(hi), 64'd0);

        // No D-stage MD instruction: no stall even while busy.
        md_instr_D = 1'b0;
        start = 1'b1; md_op = MD_DIVU; srcA = 32'd100; srcB = 32'd7;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < DC; i++) begin
            #1 check($sformatf("nostall busy%0d", i), {62'd0, busy, md_stall_req}, 64'd2);
            @(negedge clk);
        end
        check("divu100/7 lo", 64'(lo), 64'd14);
        check("divu100/7 hi", 64'(hi), 64'd2);

        // Reset in busy cycle 4 of a divide aborts with no commit.
        start = 1'b1; md_op = MD_DIV; srcA = 32'd100; srcB = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-reset busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort hi", 64'(hi), 64'd0);
        check("abort lo", 64'(lo), 64'd0);
        repeat (DC) @(negedge clk);
        check("abort no commit", {31'd0, busy, hi}, 64'd0);
        mHi = 32'd0; mLo = 32'd0;
        runOp("post-reset multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0,
              32'd1, 32'hFFFF_FFFE, MC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mdu_sched.md
Name: mdu_sched

Overview:
- Multi-cycle multiply/divide sequencer for the 5-stage MIPS core. Sits beside the E-stage ALU.
- Accepts mult/multu/div/divu/mthi/mtlo from E and runs a fixed-latency countdown. Owns the HI/LO registers.
- Raises a stall request so the hazard unit holds any MD-class instruction in D while the unit is occupied.

Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu (and madd/maddu when enabled); legal range 1..15.
- DIV_CYCLES, 10: busy cycles for div/divu; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  E-stage MD instruction valid this cycle
- md_op  in  4  operation code from shared package, sampled when start=1
- srcA  in  32  forwarded rs value (E stage)
- srcB  in  32  forwarded rt value (E stage)
- md_instr_D  in  1  D-stage instruction is MD-class (mult/div/mfhi/mflo/mthi/mtlo/madd)
- busy  out  1  countdown in progress
- hi  out  32  HI register
- lo  out  32  LO register
- md_stall_req  out  1  to hazard unit; ORed into stall

Behaviour:
- Reset: state=IDLE, busy=0, hi=0, lo=0, counter=0. Reset has priority over every other event and aborts an operation in progress with no commit.
- Op codes: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 8 MADD, 9 MADDU. All other codes are NOP.
- IDLE, start=1, op in {1..4,8,9}:
  - latch op, srcA and srcB; load counter with N (MULT_CYCLES or DIV_CYCLES); go to BUSY.
- IDLE, start=1, op=MTHI: hi<=srcA at the same edge. op=MTLO: lo<=srcA. State stays IDLE.
- BUSY: counter decrements each cycle. busy=1 in every BUSY cycle.
  - At the edge where counter==1, commit the result to hi/lo and return to IDLE.
- Timing: start sampled at edge t, so busy=1 for exactly N cycles after t. New hi/lo and busy=0 become visible at the same edge.
- hi and lo hold their old values throughout BUSY.
- start=1 while BUSY is ignored, with no side effects. The hazard unit guarantees this does not happen; it is a bench assertion only.
- MULT: {hi,lo} = signed 64-bit product. MULTU: unsigned 64-bit product.
- DIV:
  - lo = quotient truncated toward zero; hi = remainder, carrying the sign of the dividend.
  - Special case 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- DIVU: unsigned quotient to lo, unsigned remainder to hi.
- Divide by zero (div or divu): full DIV_CYCLES busy period runs, then hi/lo are left unchanged.
- md_stall_req = md_instr_D & (start | busy). This is combinational; no registered delay.
- mfhi/mflo read hi/lo combinationally in E. The stall rule guarantees no read occurs while busy.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: op 8 gives {hi,lo} <= {hi,lo} + signed product; op 9 gives {hi,lo} <= {hi,lo} + unsigned product. Both use MULT_CYCLES, with the 64-bit add wrapping modulo 2^64. The accumulator base is the hi/lo value at commit time.
- Undefined: ops 8 and 9 decode as NOP, and no adder is generated.

Decomposition:
- Package mdu_pkg holds:
  - op code localparams (MD_NOP ... MD_MADDU)
  - state encoding (ST_IDLE, ST_BUSY)
  - counter width constant, 4 bits
- One sub-module, mdu_calc: purely combinational.
  - Inputs: latched op, latched operands, current hi/lo.
  - Outputs: next hi, next lo, and a commit-enable that is low on divide by zero.
- mdu_sched keeps the FSM, counter, registers and stall logic.

Test Plan:
- MULT, srcA=0xFFFFFFFD (-3), srcB=5 -> busy=1 for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1, busy=0.
- DIVU 7/2 -> busy=1 for 10 cycles, then lo=3, hi=1. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- MTHI 0x12345678, then DIV 9/0 -> hi=0x12345678 and lo unchanged after 10 busy cycles.
- Stall:
  - md_instr_D=1 held from the start cycle of a MULT -> md_stall_req=1 in the start cycle and in all 5 busy cycles; 0 in the first cycle after busy falls.
  - md_instr_D=0 during BUSY -> md_stall_req=0.
- Reset mid-operation: DIV started, reset asserted at busy cycle 4 -> next cycle busy=0, hi=lo=0. A following MULTU 0xFFFFFFFF*2 then yields hi=1, lo=0xFFFFFFFE.
- MDU_MADD_EN defined: hi=0, lo=0xFFFFFFFF, MADDU 1*1 -> hi=1, lo=0. Undefined: same stimulus leaves hi/lo unchanged and busy stays 0.
